// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared PS/2 types and constants for the host transmit and
//                device receive paths.
//  Revision    : 1.0
// ============================================================================
package ps2_pkg;

    typedef enum logic [2:0] {
        TX_IDLE     = 3'd0,
        TX_INHIBIT  = 3'd1,
        TX_SEND     = 3'd2,
        TX_ACK      = 3'd3,
        TX_WAITIDLE = 3'd4,
        TX_DONE     = 3'd5,
        TX_FAIL     = 3'd6
    } tx_state_t;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ECHO    = 8'hEE;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    localparam logic [7:0] RSP_ACK     = 8'hFA;
    localparam logic [7:0] RSP_BAT_OK  = 8'hAA;

    localparam logic [7:0] BREAK_CODE  = 8'hF0;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx_if
//  Description : CPU-side command/handshake bundle of the PS/2 host transmitter.
//  Revision    : 1.0
// ============================================================================
interface ps2_host_tx_if;

    logic       start;
    logic [7:0] tx_data;
    logic       busy;
    logic       tx_active;
    logic       Hready;
    logic       error;

    modport master (
        output start,
        output tx_data,
        input  busy,
        input  tx_active,
        input  Hready,
        input  error
    );

    modport slave (
        input  start,
        input  tx_data,
        output busy,
        output tx_active,
        output Hready,
        output error
    );

endinterface : ps2_host_tx_if
`default_nettype wire

// File: rtl/ps2_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_sync_edge
//  Description : Multi-stage synchronizer with falling-edge detect per line.
//  Revision    : 1.0
// ============================================================================
module ps2_sync_edge #(
    parameter int WIDTH  = 2,
    parameter int STAGES = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] sync,
    output logic      [WIDTH-1:0] fe
);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_line
            logic [STAGES-1:0] r_pipe;
            logic              r_prev;

            // Idle PS/2 lines float high, so reset to 1 to avoid a false edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pipe <= '1;
                    r_prev <= 1'b1;
                end else begin
                    r_pipe <= (r_pipe << 1) | STAGES'(din[i]);
                    r_prev <= r_pipe[STAGES-1];
                end
            end

            assign sync[i] = r_pipe[STAGES-1];
            assign fe[i]   = r_prev & ~r_pipe[STAGES-1];
        end
    endgenerate

endmodule : ps2_sync_edge
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : PS/2 host-to-device command transmitter with ACK check and
//                timeout; drives the shared lines through open-drain enables.
//  Revision    : 1.0
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,    // must be >= 2
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
) (
    input  wire logic     Hclock,
    input  wire logic     Hreset,
    ps2_host_tx_if.slave  bus,
    input  wire logic     ps2clk_in,
    input  wire logic     ps2data_in,
    output logic          ps2clk_oe,
    output logic          ps2data_oe
);

    localparam int MAX_COUNT = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES
                                                                 : INHIBIT_CYCLES;
    localparam int TW        = $clog2(MAX_COUNT + 1);

    localparam logic [TW-1:0] c_inhibit_pre  = TW'(INHIBIT_CYCLES - 2);
    localparam logic [TW-1:0] c_inhibit_last = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] c_timeout_last = TW'(TIMEOUT_CYCLES - 1);

    tx_state_t     r_state;
    logic [8:0]    r_shift;
    logic [3:0]    r_bitcnt;
    logic [TW-1:0] r_timer;
    logic          r_busy;
    logic          r_tx_active;
    logic          r_hready;
    logic          r_error;
    logic          r_clk_oe;
    logic          r_data_oe;

    logic          w_clk_sync;
    logic          w_data_sync;
    logic          w_clk_fe;
    logic          w_unused_data_fe;
    logic          w_timed;
    logic          w_timeout;
    logic          w_nack;
    logic          w_fail;

    ps2_sync_edge #(
        .WIDTH  (2),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (Hclock),
        .rst_n (Hreset),
        .din   ({ps2data_in, ps2clk_in}),
        .sync  ({w_data_sync, w_clk_sync}),
        .fe    ({w_unused_data_fe, w_clk_fe})
    );

    // The device-clocked phases share one watchdog; timeout beats any edge.
    assign w_timed   = (r_state == TX_SEND) || (r_state == TX_ACK) ||
                       (r_state == TX_WAITIDLE);
    assign w_timeout = w_timed && (r_timer == c_timeout_last);
    assign w_nack    = (r_state == TX_ACK) && w_clk_fe && w_data_sync;
    assign w_fail    = w_timeout || w_nack;

    always_ff @(posedge Hclock or negedge Hreset) begin
        if (!Hreset) begin
            r_state     <= TX_IDLE;
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_timer     <= '0;
            r_busy      <= 1'b0;
            r_tx_active <= 1'b0;
            r_hready    <= 1'b0;
            r_error     <= 1'b0;
            r_clk_oe    <= 1'b0;
            r_data_oe   <= 1'b0;
        end else begin
            r_hready <= 1'b0;
            r_error  <= 1'b0;

            if (w_fail) begin
                r_error     <= 1'b1;
                r_busy      <= 1'b0;
                r_tx_active <= 1'b0;
                r_clk_oe    <= 1'b0;
                r_data_oe   <= 1'b0;
                r_state     <= TX_FAIL;
            end else begin
                case (r_state)
                    TX_IDLE: begin
                        if (bus.start) begin
                            r_shift     <= {odd_parity(bus.tx_data), bus.tx_data};
                            r_bitcnt    <= '0;
                            r_timer     <= '0;
                            r_busy      <= 1'b1;
                            r_tx_active <= 1'b1;
                            r_clk_oe    <= 1'b1;
                            r_state     <= TX_INHIBIT;
                        end
                    end

                    TX_INHIBIT: begin
                        r_timer <= r_timer + 1'b1;
                        // Start bit goes low while the clock is still held.
                        if (r_timer == c_inhibit_pre) begin
                            r_data_oe <= 1'b1;
                        end
                        if (r_timer == c_inhibit_last) begin
                            r_clk_oe <= 1'b0;
                            r_timer  <= '0;
                            r_state  <= TX_SEND;
                        end
                    end

                    TX_SEND: begin
                        r_timer <= r_timer + 1'b1;
                        if (w_clk_fe) begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                            if (r_bitcnt == 4'd9) begin
                                r_data_oe <= 1'b0;
                                r_state   <= TX_ACK;
                            end else begin
                                r_data_oe <= ~r_shift[0];
                                r_shift   <= r_shift >> 1;
                            end
                        end
                    end

                    TX_ACK: begin
                        r_timer <= r_timer + 1'b1;
                        if (w_clk_fe) begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                            r_state  <= TX_WAITIDLE;
                        end
                    end

                    TX_WAITIDLE: begin
                        r_timer <= r_timer + 1'b1;
                        if (w_clk_sync && w_data_sync) begin
                            r_hready    <= 1'b1;
                            r_busy      <= 1'b0;
                            r_tx_active <= 1'b0;
                            r_state     <= TX_DONE;
                        end
                    end

                    TX_DONE: r_state <= TX_IDLE;
                    TX_FAIL: r_state <= TX_IDLE;
                    default: r_state <= TX_IDLE;
                endcase
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.tx_active = r_tx_active;
    assign bus.Hready    = r_hready;
    assign bus.error     = r_error;
    assign ps2clk_oe     = r_clk_oe;
    assign ps2data_oe    = r_data_oe;

endmodule : ps2_host_tx
`default_nettype wire
